// File: rtl/scan_pkg.sv
// Shared types and sizes for the channel scanner.
// ST_GAP only exists when SCAN_GAP_EN is defined.
package scan_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1
`ifdef SCAN_GAP_EN
        ,
        ST_GAP   = 2'd2
`endif
    } state_t;

endpackage

// File: rtl/scan_next_ch.sv
// Wrap-around search for the first set mask bit above cur_ch; cur_ch itself is tried last.
// Purely combinational; wrap flags a result at or below cur_ch, none flags an empty mask.
module scan_next_ch
    import scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur_ch,
    output logic [CH_W-1:0]   next_ch,
    output logic              wrap,
    output logic              none
);

    logic            found;
    logic [CH_W-1:0] idx;

    always_comb begin
        next_ch = cur_ch;
        found   = 1'b0;
        idx     = cur_ch;
        // Offset NUM_CH truncates to zero, so the current channel is the final candidate.
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = cur_ch + CH_W'(i);
            if (!found && mask[idx]) begin
                next_ch = idx;
                found   = 1'b1;
            end
        end
        none = ~|mask;
        wrap = (next_ch <= cur_ch);
    end

endmodule

// File: rtl/channel_scanner.sv
// Sweeps enabled channels onto a 3-to-8 decoder, holding each for dwell+1 cycles; all outputs registered.
// Define SCAN_GAP_EN for a one-cycle en=0 gap (next code already shown) between consecutive dwells.
module channel_scanner
    import scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [NUM_CH-1:0]  mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               en,
    output logic               busy,
    output logic               sweep_done
);

    state_t             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CH_W-1:0]    search_ch;
    logic [CH_W-1:0]    nxt_ch;
    logic               nxt_wrap;
    logic               nxt_none;

    // Searching from the top channel while idle yields the lowest set bit for start.
    assign search_ch = (state_q == ST_IDLE) ? CH_W'(NUM_CH - 1) : ch_q;

    scan_next_ch u_next (
        .mask    (mask),
        .cur_ch  (search_ch),
        .next_ch (nxt_ch),
        .wrap    (nxt_wrap),
        .none    (nxt_none)
    );

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            ch_d    = '0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !nxt_none) begin
                        state_d = ST_DWELL;
                        ch_d    = nxt_ch;
                        cnt_d   = dwell;
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else if (nxt_none || (nxt_wrap && !mode)) begin
                        state_d = ST_IDLE;
                        ch_d    = '0;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = !nxt_none;
                    end else begin
                        ch_d   = nxt_ch;
                        done_d = nxt_wrap;
`ifdef SCAN_GAP_EN
                        state_d = ST_GAP;
                        en_d    = 1'b0;
`else
                        cnt_d   = dwell;
`endif
                    end
                end
`ifdef SCAN_GAP_EN
                ST_GAP: begin
                    state_d = ST_DWELL;
                    cnt_d   = dwell;
                    en_d    = 1'b1;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    ch_d    = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign {a, b, c}  = ch_q;
    assign en         = en_q;
    assign busy       = busy_q;
    assign sweep_done = done_q;

endmodule
